apb_master: RTL and testbench

APB master stage that converts a simple valid/ready command stream into APB4 SETUP/ACCESS transfers. It drives the APB slave under test and the protocol checker, and returns one response per command to the issuing agent. It supports slave wait states, back-to-back transfers and an optional access timeout.

---
 rtl/apb_master_if.sv | 75 +++++++
 rtl/apb_master.sv | 170 +++++++++++++++++
 tb/tb_apb_master.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
//
// Purpose:
//    Bundles the command/response stream and the APB4 bus of the apb_master
//    stage into one interface, so the master and its environment can be
//    connected with a single port.
//
// Parameters:
//    DATA_WIDTH  APB data width
//    ADDR_WIDTH  APB address width
//
// Signals (direction seen from the master modport):
//    cmd_valid   in   command present
//    cmd_ready   out  command accepted when cmd_valid && cmd_ready
//    cmd_write   in   1 = write, 0 = read
//    cmd_addr    in   transfer address
//    cmd_wdata   in   write data
//    cmd_strb    in   write byte strobes
//    rsp_valid   out  single-cycle response pulse
//    rsp_rdata   out  read data (0 for writes and timeouts)
//    rsp_err     out  timeout indication, qualified by rsp_valid
//    PSELx       out  APB select
//    PENABLE     out  APB enable
//    PWRITE      out  APB direction
//    PADDR       out  APB address
//    PSTRB       out  APB byte strobes
//    PWDATA      out  APB write data
//    PRDATA      in   APB read data
//    PREADY      in   APB slave ready
// ---------------------------------------------------------------------------
interface apb_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int NBYTES = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [NBYTES-1:0]     cmd_strb;

   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [NBYTES-1:0]     PSTRB;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;

   // The master owns the APB request side and the response stream.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  PRDATA, PREADY,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output PSELx, PENABLE, PWRITE, PADDR, PSTRB, PWDATA
   );

   // The environment side: issues commands, plays the APB slave.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output PRDATA, PREADY,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  PSELx, PENABLE, PWRITE, PADDR, PSTRB, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose:
//    Converts a valid/ready command stream into APB4 SETUP/ACCESS transfers
//    and returns exactly one single-cycle response per command. Supports
//    slave wait states and back-to-back transfers (one per two cycles).
//
// Optional feature (compile-time macro):
//    APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees no PREADY
//                           for TIMEOUT_CYCLES cycles is abandoned and a
//                           response with rsp_err=1 is issued. When undefined
//                           ACCESS waits forever and rsp_err is tied to 0.
//
// Ports:
//    PCLK    in  clock
//    PRESET  in  synchronous active-high reset
//    bus     apb_master_if.master, carrying the command stream, the
//            response stream and the APB4 bus signals
// ---------------------------------------------------------------------------
module apb_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int NBYTES         = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic          PCLK,
   input logic          PRESET,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   state_e                state_q;
   state_e                state_d;

   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [NBYTES-1:0]     pstrb_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  rspValid_q;
   logic [DATA_WIDTH-1:0] rspRdata_q;

   logic                  cmdReady;
   logic                  accept;
   logic                  done;
   logic                  timeoutHit;
   logic                  pselx;
   logic                  penable;

   // A new command can be taken while idle, or in the very cycle the current
   // transfer completes, which is what gives ACCESS -> SETUP back-to-back.
   // Reset blocks acceptance so nothing is registered while PRESET is high.
   assign cmdReady = !PRESET && ((state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY));
   assign accept   = bus.cmd_valid && cmdReady;
   assign done     = (state_q == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmoCount_q;
   logic             rspErr_q;

   // tmoCount_q holds the number of earlier wait cycles in this ACCESS, so
   // the current cycle is the TIMEOUT_CYCLES-th one when it equals
   // TIMEOUT_CYCLES-1. A PREADY in that same cycle still wins.
   assign timeoutHit = (state_q == ACCESS) && !bus.PREADY &&
                       (tmoCount_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Wait-state counter: cleared while in SETUP so it starts from zero on
   // entry to ACCESS, then advanced once per ACCESS cycle without PREADY.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tmoCount_q <= '0;
      end else if (state_q == SETUP) begin
         tmoCount_q <= '0;
      end else if ((state_q == ACCESS) && !bus.PREADY) begin
         tmoCount_q <= tmoCount_q + TMO_W'(1);
      end
   end

   // The error flag is a one-cycle companion of the response pulse.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         rspErr_q <= 1'b0;
      end else begin
         rspErr_q <= timeoutHit;
      end
   end

   assign bus.rsp_err = rspErr_q;
`else
   assign timeoutHit  = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   // Next-state logic and APB control decode. SETUP always lasts one cycle;
   // ACCESS ends on PREADY (going straight to SETUP if another command is
   // taken in that cycle) or on a timeout.
   always_comb begin
      state_d = state_q;
      pselx   = 1'b0;
      penable = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            pselx   = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            pselx   = 1'b1;
            penable = 1'b1;
            if (bus.PREADY) begin
               state_d = accept ? SETUP : IDLE;
            end else if (timeoutHit) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register, command capture and response generation. The APB
   // request fields are only written on accept, so they stay frozen from
   // SETUP through the completing ACCESS cycle. Reads never drive strobes.
   // The response data register is reloaded every cycle so it reads 0
   // whenever no read is completing.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= IDLE;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pstrb_q    <= '0;
         pwdata_q   <= '0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
         end
         rspValid_q <= done || timeoutHit;
         rspRdata_q <= (done && !pwrite_q) ? bus.PRDATA : '0;
      end
   end

   assign bus.cmd_ready = cmdReady;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_rdata = rspRdata_q;
   assign bus.PSELx     = pselx;
   assign bus.PENABLE   = penable;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PSTRB     = pstrb_q;
   assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Purpose:
//    Self-checking bench for apb_master. Commands are driven on the interface,
//    a simple APB slave answers with planned wait states and read data, and a
//    transaction-level model predicts each response (cycle, data, error).
//    Build with APB_MASTER_TIMEOUT_EN defined to also exercise the timeout.
// ---------------------------------------------------------------------------
module tb_apb_master;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NB  = DW / 8;
   localparam int TMO = 16;

   typedef struct {
      int            cyc;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   logic PCLK = 1'b0;
   logic PRESET;

   apb_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   apb_master #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .NBYTES        (NB),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK  (PCLK),
      .PRESET(PRESET),
      .bus   (bus)
   );

   always #5 PCLK = ~PCLK;

   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;
   bit            lastAccept;
   int            xferIdx = 0;
   int            slvIdx  = 0;
   int            slvWait = 0;
   logic [DW-1:0] slvData;
   int            planWait[int];
   logic [DW-1:0] planData[int];
   rsp_t          expQ[$];
   rsp_t          obsQ[$];
   logic          lastWrite;
   logic [AW-1:0] lastAddr;
   logic [DW-1:0] lastWdata;
   logic [NB-1:0] lastStrb;

   // One clock cycle: notes whether the command is taken at the coming edge
   // (and predicts its response), then after the edge logs any response and
   // plays the APB slave for the new cycle. Returns just after the falling
   // edge, where outputs are stable and inputs may be changed.
   task automatic step();
      int   w;
      bit   rstEdge;
      rsp_t e;
      rsp_t o;
      rsp_t keep[$];
      #2;
      rstEdge    = (PRESET === 1'b1);
      lastAccept = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1);
      if (lastAccept) begin
         w         = planWait.exists(xferIdx) ? planWait[xferIdx] : 0;
         lastWrite = bus.cmd_write;
         lastAddr  = bus.cmd_addr;
         lastWdata = bus.cmd_wdata;
         lastStrb  = bus.cmd_strb;
`ifdef APB_MASTER_TIMEOUT_EN
         e.err = (w >= TMO);
`else
         e.err = 1'b0;
`endif
         e.cyc = e.err ? (cyc + 2 + TMO) : (cyc + 3 + w);
         if (e.err || bus.cmd_write) e.rdata = '0;
         else if (planData.exists(xferIdx)) e.rdata = planData[xferIdx];
         else e.rdata = '0;
         expQ.push_back(e);
         xferIdx++;
      end
      @(negedge PCLK);
      cyc++;
      if (rstEdge) begin
         foreach (expQ[i]) if (expQ[i].cyc < cyc) keep.push_back(expQ[i]);
         expQ = keep;
      end
      if (bus.rsp_valid === 1'b1) begin
         o.cyc   = cyc;
         o.rdata = bus.rsp_rdata;
         o.err   = bus.rsp_err;
         obsQ.push_back(o);
      end
      if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b0) begin
         slvWait    = planWait.exists(slvIdx) ? planWait[slvIdx] : 0;
         slvData    = planData.exists(slvIdx) ? planData[slvIdx] : '0;
         slvIdx++;
         bus.PREADY = 1'b0;
         bus.PRDATA = $urandom;
      end else if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1) begin
         if (slvWait > 0) begin
            bus.PREADY = 1'b0;
            bus.PRDATA = $urandom;
            slvWait--;
         end else begin
            bus.PREADY = 1'b1;
            bus.PRDATA = slvData;
         end
      end else begin
         bus.PREADY = 1'b0;
         bus.PRDATA = $urandom;
      end
      #1;
   endtask

   // Holding reset with a pending command must leave every output at zero
   // and the block must be ready in the first cycle after release.
   task automatic test_reset();
      PRESET        = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'hF;
      repeat (3) step();
      checks++;
      if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got sel,en,wr,rv,err,rdy=%b%b%b%b%b%b, need 000000",
                  bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready);
      end
      checks++;
      if (bus.PADDR !== '0 || bus.PSTRB !== '0 || bus.PWDATA !== '0 || bus.rsp_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: got addr=%h strb=%h wdata=%h rdata=%h, need all 0",
                  bus.PADDR, bus.PSTRB, bus.PWDATA, bus.rsp_rdata);
      end
      PRESET        = 1'b0;
      bus.cmd_valid = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: got %b, need 1", bus.cmd_ready);
      end
      expQ.delete();
      obsQ.delete();
   endtask

   // Single write with no wait states: SETUP, ACCESS, response at N+3.
   task automatic test_single_write();
      planWait[xferIdx] = 0;
      planData[xferIdx] = $urandom;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h10;
      bus.cmd_wdata = 32'hDEADBEEF;
      bus.cmd_strb  = 4'hF;
      step();
      checks++;
      if (lastAccept !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_accept: got %b, need 1", lastAccept);
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({bus.PSELx, bus.PENABLE} !== {1'b1, k == 1}) begin
            errors++;
            $display("[TB] FAIL write_phase%0d: got sel,en=%b%b, need 1%0d", k, bus.PSELx, bus.PENABLE, k);
         end
         checks++;
         if (bus.PADDR !== 32'h10 || bus.PWDATA !== 32'hDEADBEEF || bus.PSTRB !== 4'hF || bus.PWRITE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_fields%0d: got addr=%h wdata=%h strb=%h wr=%b, need 10 deadbeef f 1",
                     k, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE);
         end
         step();
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0 || bus.PSELx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_rsp: got rv=%b err=%b rdata=%h sel=%b, need 1 0 0 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSELx);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_rsp_pulse: got rv=%b, need 0", bus.rsp_valid);
      end
   endtask

   // Read with two wait states and a full strobe on the command: strobes are
   // zero, fields are stable through all ACCESS cycles, data 5 cycles later.
   task automatic test_wait_read();
      planWait[xferIdx] = 2;
      planData[xferIdx] = 32'hCAFEF00D;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h20;
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'hF;
      step();
      checks++;
      if (lastAccept !== 1'b1) begin
         errors++;
         $display("[TB] FAIL read_accept: got %b, need 1", lastAccept);
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      checks++;
      if ({bus.PSELx, bus.PENABLE} !== 2'b10 || bus.PSTRB !== '0 || bus.PADDR !== 32'h20 || bus.PWRITE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_setup: got sel,en=%b%b strb=%h addr=%h wr=%b, need 10 0 20 0",
                  bus.PSELx, bus.PENABLE, bus.PSTRB, bus.PADDR, bus.PWRITE);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({bus.PSELx, bus.PENABLE} !== 2'b11 || bus.PSTRB !== '0 || bus.PADDR !== 32'h20 ||
             bus.PWRITE !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_access%0d: got sel,en=%b%b strb=%h addr=%h wr=%b rv=%b, need 11 0 20 0 0",
                     k, bus.PSELx, bus.PENABLE, bus.PSTRB, bus.PADDR, bus.PWRITE, bus.rsp_valid);
         end
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFEF00D || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_rsp: got rv=%b rdata=%h err=%b, need 1 cafef00d 0",
                  bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
      end
   endtask

   // Write then read with cmd_valid held: PSELx stays high across the
   // ACCESS->SETUP boundary and the two responses come two cycles apart.
   task automatic test_back_to_back();
      bit pselExp[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bit penExp[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      bit rspExp[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int accAt = -1;
      planWait[xferIdx]     = 0;
      planData[xferIdx]     = $urandom;
      planWait[xferIdx + 1] = 0;
      planData[xferIdx + 1] = 32'h1234_5678;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'h3;
      step();
      checks++;
      if (lastAccept !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_accept: got %b, need 1", lastAccept);
      end
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h4;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.PSELx !== pselExp[k] || bus.PENABLE !== penExp[k] || bus.rsp_valid !== rspExp[k]) begin
            errors++;
            $display("[TB] FAIL b2b_cycle%0d: got sel,en,rv=%b%b%b, need %b%b%b",
                     k + 1, bus.PSELx, bus.PENABLE, bus.rsp_valid, pselExp[k], penExp[k], rspExp[k]);
         end
         if (k == 2) begin
            checks++;
            if (bus.PADDR !== 32'h4 || bus.PWRITE !== 1'b0 || bus.PSTRB !== '0) begin
               errors++;
               $display("[TB] FAIL b2b_second_setup: got addr=%h wr=%b strb=%h, need 4 0 0",
                        bus.PADDR, bus.PWRITE, bus.PSTRB);
            end
         end
         if (k == 4) begin
            checks++;
            if (bus.rsp_rdata !== 32'h1234_5678) begin
               errors++;
               $display("[TB] FAIL b2b_read_data: got %h, need 12345678", bus.rsp_rdata);
            end
         end
         if (k < 4) begin
            step();
            if (lastAccept) begin
               bus.cmd_valid = 1'b0;
               accAt = k;
            end
         end
      end
      checks++;
      if (accAt != 1) begin
         errors++;
         $display("[TB] FAIL b2b_accept_cycle: got step %0d, need 1", accAt);
      end
   endtask

   // Reset in the completing ACCESS cycle of a read: everything clears and
   // the dropped read never produces a response.
   task automatic test_reset_abort();
      planWait[xferIdx] = 0;
      planData[xferIdx] = $urandom;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_strb  = 4'hF;
      step();
      bus.cmd_valid = 1'b0;
      step();
      checks++;
      if ({bus.PSELx, bus.PENABLE} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL abort_in_access: got sel,en=%b%b, need 11", bus.PSELx, bus.PENABLE);
      end
      PRESET        = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = $urandom;
      step();
      checks++;
      if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 6'b0 ||
          bus.PADDR !== '0 || bus.PSTRB !== '0 || bus.PWDATA !== '0 || bus.rsp_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL abort_clear: got sel,en,wr,rv,err,rdy=%b%b%b%b%b%b addr=%h rdata=%h, need all 0",
                  bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.cmd_ready,
                  bus.PADDR, bus.rsp_rdata);
      end
      checks++;
      if (lastAccept !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_no_accept: got %b, need 0", lastAccept);
      end
      PRESET        = 1'b0;
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.PSELx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet%0d: got rv=%b sel=%b, need 0 0", k, bus.rsp_valid, bus.PSELx);
         end
      end
   endtask

   // Random commands, gaps and wait states; every APB cycle is checked
   // against the last accepted command and all responses against the model.
   task automatic test_random();
      int sent   = 0;
      int budget = 0;
      expQ.delete();
      obsQ.delete();
      bus.cmd_valid = 1'b0;
      while (sent < 40 && budget < 2000) begin
         budget++;
         if (bus.cmd_valid !== 1'b1 && $urandom_range(0, 2) != 0) begin
            planWait[xferIdx] = $urandom_range(0, 3);
            planData[xferIdx] = $urandom;
            bus.cmd_valid = 1'b1;
            bus.cmd_write = $urandom_range(0, 1);
            bus.cmd_addr  = $urandom;
            bus.cmd_wdata = $urandom;
            bus.cmd_strb  = $urandom;
         end
         step();
         if (lastAccept) begin
            sent++;
            bus.cmd_valid = 1'b0;
         end
         if (bus.PSELx === 1'b1) begin
            checks++;
            if (bus.PADDR !== lastAddr || bus.PWRITE !== lastWrite || bus.PWDATA !== lastWdata ||
                bus.PSTRB !== (lastWrite ? lastStrb : 4'h0)) begin
               errors++;
               $display("[TB] FAIL rand_fields: got addr=%h wr=%b wdata=%h strb=%h, need %h %b %h %h",
                        bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB, lastAddr, lastWrite, lastWdata,
                        lastWrite ? lastStrb : 4'h0);
            end
         end
      end
      checks++;
      if (sent != 40) begin
         errors++;
         $display("[TB] FAIL rand_progress: got %0d accepted, need 40", sent);
      end
      bus.cmd_valid = 1'b0;
      repeat (8) step();
      checks++;
      if (obsQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL rand_rsp_count: got %0d, need %0d", obsQ.size(), expQ.size());
      end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].rdata !== expQ[i].rdata || obsQ[i].err !== expQ[i].err) begin
            errors++;
            $display("[TB] FAIL rand_rsp%0d: got cyc=%0d rdata=%h err=%b, need cyc=%0d rdata=%h err=%b",
                     i, obsQ[i].cyc, obsQ[i].rdata, obsQ[i].err, expQ[i].cyc, expQ[i].rdata, expQ[i].err);
         end
      end
   endtask

`ifdef APB_MASTER_TIMEOUT_EN
   // A silent slave times out after TMO ACCESS cycles with an error; a slave
   // answering in the TMO-th cycle completes normally; the block recovers.
   task automatic test_timeout();
      int waits[3]     = '{1000, TMO - 1, 0};
      bit writes[3]    = '{1'b0, 1'b0, 1'b1};
      int accessCnt;
      expQ.delete();
      obsQ.delete();
      for (int n = 0; n < 3; n++) begin
         planWait[xferIdx] = waits[n];
         planData[xferIdx] = $urandom;
         bus.cmd_valid = 1'b1;
         bus.cmd_write = writes[n];
         bus.cmd_addr  = $urandom;
         bus.cmd_wdata = $urandom;
         bus.cmd_strb  = $urandom;
         accessCnt = 0;
         for (int k = 0; k < 4 && bus.cmd_valid === 1'b1; k++) begin
            step();
            if (lastAccept) bus.cmd_valid = 1'b0;
         end
         checks++;
         if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_accept%0d: not accepted, need accept", n);
            bus.cmd_valid = 1'b0;
         end
         repeat (TMO + 6) begin
            if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1) accessCnt++;
            step();
         end
         if (n == 0) begin
            checks++;
            if (accessCnt != TMO) begin
               errors++;
               $display("[TB] FAIL tmo_access_len: got %0d cycles, need %0d", accessCnt, TMO);
            end
         end
      end
      checks++;
      if (obsQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL tmo_rsp_count: got %0d, need %0d", obsQ.size(), expQ.size());
      end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].rdata !== expQ[i].rdata || obsQ[i].err !== expQ[i].err) begin
            errors++;
            $display("[TB] FAIL tmo_rsp%0d: got cyc=%0d rdata=%h err=%b, need cyc=%0d rdata=%h err=%b",
                     i, obsQ[i].cyc, obsQ[i].rdata, obsQ[i].err, expQ[i].cyc, expQ[i].rdata, expQ[i].err);
         end
      end
   endtask
`endif

   // Safety net so the run always ends even if a wait never resolves.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence.
   initial begin
      PRESET        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b0;
      test_reset();
      test_single_write();
      test_wait_read();
      test_back_to_back();
      test_reset_abort();
      test_random();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
